mmc1_cpu_mapper: RTL

MMC1_CPU_MAPPER -- requirements
Module: mmc1_cpu_mapper

---
 rtl/nes_mapper_pkg.sv | 25 ++
 rtl/mmc1_shift_reg.sv | 49 ++++
 rtl/mmc1_cpu_mapper.sv | 121 ++++++++++++
 3 files changed

// File: rtl/nes_mapper_pkg.sv
// rtl/nes_mapper_pkg.sv - shared types and constants for the NES MMC1 CPU-side mapper
package nes_mapper_pkg;

  typedef enum logic [1:0] {
    MIRROR_ONE_LOW  = 2'd0,
    MIRROR_ONE_HIGH = 2'd1,
    MIRROR_VERTICAL = 2'd2,
    MIRROR_HORIZ    = 2'd3
  } mirroring_e;

  typedef enum logic [1:0] {
    REG_CONTROL = 2'd0,
    REG_CHR0    = 2'd1,
    REG_CHR1    = 2'd2,
    REG_PRG     = 2'd3
  } mmc1_reg_e;

  localparam logic [1:0] PRG_MODE_32K_0     = 2'd0;
  localparam logic [1:0] PRG_MODE_32K_1     = 2'd1;
  localparam logic [1:0] PRG_MODE_FIX_FIRST = 2'd2;
  localparam logic [1:0] PRG_MODE_FIX_LAST  = 2'd3;

  localparam logic [4:0] CONTROL_RESET = 5'h0C;

endpackage

// File: rtl/mmc1_shift_reg.sv
// rtl/mmc1_shift_reg.sv - MMC1 serial port: 5-bit LSB-first shifter with write filter
module mmc1_shift_reg
  import nes_mapper_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       rom_wr,
  input  logic       bit_in,
  input  logic       clear_in,
  output logic       load,
  output logic [4:0] load_value,
  output logic       ctrl_reset
);

  logic [4:0] shift;
  logic [2:0] count;
  logic       filter;
  logic       accept;
  logic       unused_shift_lsb;

  // A write directly following another ROM write is the second half of a
  // read-modify-write instruction and must not shift again.
  assign accept     = rom_wr && !filter;
  assign ctrl_reset = accept && clear_in;
  assign load       = accept && !clear_in && (count == 3'd4);
  assign load_value = {bit_in, shift[4:1]};

  assign unused_shift_lsb = shift[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      shift  <= 5'd0;
      count  <= 3'd0;
      filter <= 1'b0;
    end else begin
      filter <= rom_wr;
      if (accept) begin
        if (clear_in || count == 3'd4) begin
          shift <= 5'd0;
          count <= 3'd0;
        end else begin
          shift <= {bit_in, shift[4:1]};
          count <= count + 3'd1;
        end
      end
    end
  end

endmodule

// File: rtl/mmc1_cpu_mapper.sv
// rtl/mmc1_cpu_mapper.sv - MMC1 CPU address decode, bank registers and PRG/CHR mapping
module mmc1_cpu_mapper
  import nes_mapper_pkg::*;
#(
  parameter int PRG_BANKS  = 8,
  parameter int PRG_ADDR_W = 14 + $clog2(PRG_BANKS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  WE,
  input  logic [15:0]           addr,
  input  logic [7:0]            data_in,
  input  logic [7:0]            CPU_RAM_out,
  input  logic [7:0]            PRG_ROM_out,
  input  logic [7:0]            PRG_RAM_out,
  input  logic [7:0]            vram_data_out,
  output logic [7:0]            data_out,
  output logic                  CPU_RAM_WE,
  output logic                  PRG_RAM_WE,
  output logic                  vram_WE,
  output logic [10:0]           CPU_RAM_addr,
  output logic [12:0]           PRG_RAM_addr,
  output logic [PRG_ADDR_W-1:0] PRG_ROM_addr,
  output logic [2:0]            ppu_reg_addr,
  output logic                  ppu_reg_cs,
  output logic [1:0]            mirroring,
  output logic [4:0]            chr_bank0,
  output logic [4:0]            chr_bank1
);

  localparam int         BANK_W    = PRG_ADDR_W - 14;
  localparam logic [3:0] LAST_BANK = 4'(PRG_BANKS - 1);

  logic [4:0] control;
  logic [4:0] chr0;
  logic [4:0] chr1;
  logic [4:0] prg;

  logic       sel_cpu_ram;
  logic       sel_ppu;
  logic       sel_prg_ram;
  logic       sel_prg_rom;
  logic       prg_ram_en;
  logic       rom_wr;
  logic       load;
  logic [4:0] load_value;
  logic       ctrl_reset;
  logic [3:0] bank_full;
  logic       unused_hi_bits;

  assign sel_cpu_ram = (addr[15:13] == 3'b000);
  assign sel_ppu     = (addr[15:13] == 3'b001);
  assign sel_prg_ram = (addr[15:13] == 3'b011);
  assign sel_prg_rom = addr[15];
  assign prg_ram_en  = !prg[4];
  assign rom_wr      = WE && sel_prg_rom;

  assign unused_hi_bits = ^{data_in[6:1], bank_full};

  mmc1_shift_reg u_shift (
    .clk        (clk),
    .reset      (reset),
    .rom_wr     (rom_wr),
    .bit_in     (data_in[0]),
    .clear_in   (data_in[7]),
    .load       (load),
    .load_value (load_value),
    .ctrl_reset (ctrl_reset)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      control <= CONTROL_RESET;
      chr0    <= 5'd0;
      chr1    <= 5'd0;
      prg     <= 5'd0;
    end else if (ctrl_reset) begin
      control <= control | CONTROL_RESET;
    end else if (load) begin
      case (mmc1_reg_e'(addr[14:13]))
        REG_CONTROL: control <= load_value;
        REG_CHR0:    chr0    <= load_value;
        REG_CHR1:    chr1    <= load_value;
        default:     prg     <= load_value;
      endcase
    end
  end

  always_comb begin
    bank_full = {prg[3:1], addr[14]};
    case (control[3:2])
      PRG_MODE_FIX_FIRST: bank_full = addr[14] ? prg[3:0] : 4'd0;
      PRG_MODE_FIX_LAST:  bank_full = addr[14] ? LAST_BANK : prg[3:0];
      default:            bank_full = {prg[3:1], addr[14]};
    endcase
  end

  assign PRG_ROM_addr = {bank_full[BANK_W-1:0], addr[13:0]};
  assign CPU_RAM_addr = addr[10:0];
  assign PRG_RAM_addr = addr[12:0];
  assign ppu_reg_addr = addr[2:0];
  assign ppu_reg_cs   = !sel_ppu;

  // ROM-region writes go only to the serial port, so PRG-ROM has no enable.
  assign CPU_RAM_WE = WE && sel_cpu_ram;
  assign vram_WE    = WE && sel_ppu;
  assign PRG_RAM_WE = WE && sel_prg_ram && prg_ram_en;

  always_comb begin
    data_out = 8'h00;
    if (sel_cpu_ram)                    data_out = CPU_RAM_out;
    else if (sel_ppu)                   data_out = vram_data_out;
    else if (sel_prg_ram && prg_ram_en) data_out = PRG_RAM_out;
    else if (sel_prg_rom)               data_out = PRG_ROM_out;
  end

  assign mirroring = mirroring_e'(control[1:0]);
  assign chr_bank0 = control[4] ? chr0 : {chr0[4:1], 1'b0};
  assign chr_bank1 = control[4] ? chr1 : {chr0[4:1], 1'b1};

endmodule
